// File: rtl/interface_pkg.sv
// Shared AHB encodings plus the line-fill FSM state type.
package interface_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } trans_t;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_WRAP4  = 3'b010,
        BURST_WRAP8  = 3'b100
    } burst_t;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_ADDR  = 3'd1,
        FS_BURST = 3'd2,
        FS_DRAIN = 3'd3,
        FS_DONE  = 3'd4,
        FS_ERR   = 3'd5
    } fill_state_t;

    function automatic burst_t burst_for(input int line_words);
        return (line_words == 8) ? BURST_WRAP8 : BURST_WRAP4;
    endfunction

endpackage

// File: rtl/wrap_addr_gen.sv
// Next address of a wrapping word burst: the in-line word index increments
// modulo LINE_WORDS, upper address bits are untouched.
module wrap_addr_gen #(
    parameter int LINE_WORDS = 4
) (
    input  logic [31:0] addr_i,
    output logic [31:0] next_addr_o
);
    localparam int K = $clog2(LINE_WORDS);

    logic [K-1:0] slot_inc;
    logic         unused_byte_lane;

    assign slot_inc         = addr_i[K+1:2] + K'(1);
    assign next_addr_o      = {addr_i[31:K+2], slot_inc, 2'b00};
    assign unused_byte_lane = ^addr_i[1:0];

endmodule

// File: rtl/line_fill_controller.sv
// Cache line fill engine: accepts a miss, issues one critical-word-first AHB
// wrapping read burst, forwards the first word early and returns the full line.
module line_fill_controller
    import interface_pkg::*;
#(
    parameter int LINE_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     miss_req,
    input  logic [31:0]              miss_addr,
    output logic                     miss_ack,
    output logic                     crit_valid,
    output logic [31:0]              crit_data,
    output logic                     fill_valid,
    output logic [31:0]              fill_addr,
    output logic [LINE_WORDS*32-1:0] fill_data,
    output logic                     fill_err,
    output logic [31:0]              haddr,
    output logic [1:0]               htrans,
    output logic [2:0]               hburst,
    output logic [2:0]               hsize,
    output logic                     hwrite,
    input  logic [31:0]              hrdata,
    input  logic                     hready,
    input  logic                     hresp,
    output logic [2:0]               dbg_state
);
    localparam int K  = $clog2(LINE_WORDS);
    localparam int CW = K + 1;
    localparam logic [CW-1:0] LAST_ADDR = CW'(LINE_WORDS - 1);

    fill_state_t             state_q, state_d;
    logic [31:0]             addr_q, addr_d;
    logic [CW-1:0]           acnt_q, acnt_d;
    logic                    dph_valid_q, dph_valid_d;
    logic [K-1:0]            dph_slot_q, dph_slot_d;
    logic [LINE_WORDS*32-1:0] line_q, line_d;
    logic                    crit_valid_q, crit_valid_d;
    logic [31:0]             crit_data_q, crit_data_d;
    logic                    crit_done_q, crit_done_d;
    logic [31:0]             fill_addr_q, fill_addr_d;
    logic [31:0]             addr_next;
    logic                    beat_ok, beat_err;
    logic                    unused_miss_lane;

    wrap_addr_gen #(.LINE_WORDS(LINE_WORDS)) u_wrap (
        .addr_i      (addr_q),
        .next_addr_o (addr_next)
    );

    assign hsize            = HSIZE_WORD;
    assign hwrite           = 1'b0;
    assign crit_valid       = crit_valid_q;
    assign crit_data        = crit_data_q;
    assign fill_addr        = fill_addr_q;
    assign fill_data        = line_q;
    assign dbg_state        = state_q;
    assign unused_miss_lane = ^miss_addr[1:0];

    // Handshakes: miss_req stays high until the single-cycle miss_ack; an AHB
    // address or data phase completes only in a cycle where hready=1.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        acnt_d       = acnt_q;
        dph_valid_d  = dph_valid_q;
        dph_slot_d   = dph_slot_q;
        line_d       = line_q;
        crit_valid_d = 1'b0;
        crit_data_d  = crit_data_q;
        crit_done_d  = crit_done_q;
        fill_addr_d  = fill_addr_q;
        miss_ack     = 1'b0;
        htrans       = HTRANS_IDLE;
        haddr        = 32'h0;
        hburst       = BURST_SINGLE;
        fill_valid   = 1'b0;
        fill_err     = 1'b0;

        beat_err = dph_valid_q && hresp;
        beat_ok  = dph_valid_q && hready && !hresp;

        if (beat_ok) begin
            line_d[{dph_slot_q, 5'b00000} +: 32] = hrdata;
            if (!crit_done_q) begin
                crit_valid_d = 1'b1;
                crit_data_d  = hrdata;
                crit_done_d  = 1'b1;
            end
        end
        if (hready) begin
            dph_valid_d = 1'b0;
        end

        case (state_q)
            FS_IDLE: begin
                if (miss_req && rstn) begin
                    miss_ack    = 1'b1;
                    addr_d      = {miss_addr[31:2], 2'b00};
                    fill_addr_d = {miss_addr[31:K+2], {(K+2){1'b0}}};
                    acnt_d      = '0;
                    crit_done_d = 1'b0;
                    dph_valid_d = 1'b0;
                    state_d     = FS_ADDR;
                end
            end
            FS_ADDR, FS_BURST: begin
                htrans = (state_q == FS_ADDR) ? HTRANS_NONSEQ : HTRANS_SEQ;
                haddr  = addr_q;
                hburst = burst_for(LINE_WORDS);
                if (hready) begin
                    dph_valid_d = 1'b1;
                    dph_slot_d  = addr_q[K+1:2];
                    addr_d      = addr_next;
                    acnt_d      = acnt_q + CW'(1);
                    if (state_q == FS_ADDR) begin
                        state_d = FS_BURST;
                    end else if (acnt_q == LAST_ADDR) begin
                        state_d = FS_DRAIN;
                    end
                end
            end
            FS_DRAIN: begin
                if (beat_ok) begin
                    state_d = FS_DONE;
                end
            end
            FS_DONE: begin
                fill_valid = 1'b1;
                state_d    = FS_IDLE;
            end
            FS_ERR: begin
                fill_err    = 1'b1;
                dph_valid_d = 1'b0;
                state_d     = FS_IDLE;
            end
            default: state_d = FS_IDLE;
        endcase

        // An error response wins over any address accepted in the same cycle.
        if (beat_err) begin
            state_d     = FS_ERR;
            dph_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= FS_IDLE;
            addr_q       <= '0;
            acnt_q       <= '0;
            dph_valid_q  <= 1'b0;
            dph_slot_q   <= '0;
            line_q       <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
            crit_done_q  <= 1'b0;
            fill_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            acnt_q       <= acnt_d;
            dph_valid_q  <= dph_valid_d;
            dph_slot_q   <= dph_slot_d;
            line_q       <= line_d;
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
            crit_done_q  <= crit_done_d;
            fill_addr_q  <= fill_addr_d;
        end
    end

endmodule

// File: tb/tb_line_fill_controller.sv
// Directed bench for line_fill_controller: WRAP4 and WRAP8 instances share
// stimulus, a small AHB slave model answers each burst from a fixed memory.
module tb_line_fill_controller;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic         clk, rstn, miss_req, hready, hresp, sel;
    logic [31:0]  miss_addr, hrdata;

    logic         a4_miss_ack, a4_crit_valid, a4_fill_valid, a4_fill_err, a4_hwrite;
    logic [31:0]  a4_crit_data, a4_fill_addr, a4_haddr;
    logic [127:0] a4_fill_data;
    logic [1:0]   a4_htrans;
    logic [2:0]   a4_hburst, a4_hsize, a4_dbg;

    logic         a8_miss_ack, a8_crit_valid, a8_fill_valid, a8_fill_err, a8_hwrite;
    logic [31:0]  a8_crit_data, a8_fill_addr, a8_haddr;
    logic [255:0] a8_fill_data;
    logic [1:0]   a8_htrans;
    logic [2:0]   a8_hburst, a8_hsize, a8_dbg;

    logic         m_miss_ack, m_crit_valid, m_fill_valid, m_fill_err, m_hwrite;
    logic [31:0]  m_crit_data, m_fill_addr, m_haddr;
    logic [255:0] m_fill_data;
    logic [1:0]   m_htrans;
    logic [2:0]   m_hburst, m_hsize, m_dbg;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    int           r_ack_cnt, r_ack2_cyc, r_nonseq_cyc;
    int           r_crit_cnt, r_crit_cyc, r_fill_cnt, r_fill_cyc, r_err_cnt, r_err_cyc;
    logic [31:0]  r_crit_data, r_fill_addr;
    logic [255:0] r_fill_data;
    int           cnt_fv, cnt_fe, cnt_cv;

    line_fill_controller #(.LINE_WORDS(4)) dut4 (
        .clk(clk), .rstn(rstn), .miss_req(miss_req), .miss_addr(miss_addr),
        .miss_ack(a4_miss_ack), .crit_valid(a4_crit_valid), .crit_data(a4_crit_data),
        .fill_valid(a4_fill_valid), .fill_addr(a4_fill_addr), .fill_data(a4_fill_data),
        .fill_err(a4_fill_err), .haddr(a4_haddr), .htrans(a4_htrans), .hburst(a4_hburst),
        .hsize(a4_hsize), .hwrite(a4_hwrite), .hrdata(hrdata), .hready(hready),
        .hresp(hresp), .dbg_state(a4_dbg)
    );

    line_fill_controller #(.LINE_WORDS(8)) dut8 (
        .clk(clk), .rstn(rstn), .miss_req(miss_req), .miss_addr(miss_addr),
        .miss_ack(a8_miss_ack), .crit_valid(a8_crit_valid), .crit_data(a8_crit_data),
        .fill_valid(a8_fill_valid), .fill_addr(a8_fill_addr), .fill_data(a8_fill_data),
        .fill_err(a8_fill_err), .haddr(a8_haddr), .htrans(a8_htrans), .hburst(a8_hburst),
        .hsize(a8_hsize), .hwrite(a8_hwrite), .hrdata(hrdata), .hready(hready),
        .hresp(hresp), .dbg_state(a8_dbg)
    );

    assign m_miss_ack   = sel ? a8_miss_ack   : a4_miss_ack;
    assign m_crit_valid = sel ? a8_crit_valid : a4_crit_valid;
    assign m_crit_data  = sel ? a8_crit_data  : a4_crit_data;
    assign m_fill_valid = sel ? a8_fill_valid : a4_fill_valid;
    assign m_fill_addr  = sel ? a8_fill_addr  : a4_fill_addr;
    assign m_fill_data  = sel ? a8_fill_data  : {128'b0, a4_fill_data};
    assign m_fill_err   = sel ? a8_fill_err   : a4_fill_err;
    assign m_haddr      = sel ? a8_haddr      : a4_haddr;
    assign m_htrans     = sel ? a8_htrans     : a4_htrans;
    assign m_hburst     = sel ? a8_hburst     : a4_hburst;
    assign m_hsize      = sel ? a8_hsize      : a4_hsize;
    assign m_hwrite     = sel ? a8_hwrite     : a4_hwrite;
    assign m_dbg        = sel ? a8_dbg        : a4_dbg;

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] a, input int lw);
        logic [31:0] mask;
        mask = 32'(lw * 4 - 1);
        return a & ~mask;
    endfunction

    function automatic logic [255:0] exp_line(input logic [31:0] a, input int lw);
        logic [255:0] l;
        l = '0;
        for (int i = 0; i < lw; i++) l[32*i +: 32] = mem(line_base(a, lw) + 32'(4 * i));
        return l;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic load_exp(input logic [31:0] a, input int lw);
        int slot;
        slot = int'(a[4:2]) % lw;
        for (int i = 0; i < lw; i++)
            exp_q.push_back(line_base(a, lw) + 32'(((slot + i) % lw) * 4));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            miss_req = 1'b0;
            hready   = 1'b1;
            hresp    = 1'b0;
            hrdata   = 32'hDEAD_BEEF;
        end
    endtask

    // Drives one fill from its ack (cycle 0) and acts as the AHB slave.
    task automatic run_fill(input logic [31:0] addr, input int lw, input bit toggle,
                            input int err_beat, input bit req_mode);
        logic [31:0] dph_addr, prev_haddr;
        logic [1:0]  prev_htrans;
        bit          dph_v, prev_hready, prev_hresp, first_acc, finished;
        int          beat, done_cyc, fills_needed;

        r_ack_cnt = 0; r_ack2_cyc = -1; r_nonseq_cyc = -1;
        r_crit_cnt = 0; r_crit_cyc = -1; r_fill_cnt = 0; r_fill_cyc = -1;
        r_err_cnt = 0; r_err_cyc = -1; r_crit_data = '0; r_fill_addr = '0; r_fill_data = '0;
        exp_q.delete();
        load_exp(addr, lw);

        @(negedge clk);
        miss_req = 1'b1; miss_addr = addr; hready = 1'b1; hresp = 1'b0; hrdata = 32'hDEAD_BEEF;
        #1;
        chk("ack", m_miss_ack, 1);
        prev_hready = 1'b1; prev_hresp = 1'b0; prev_htrans = m_htrans; prev_haddr = m_haddr;
        dph_v = 1'b0; dph_addr = '0; beat = 0; first_acc = 1'b1; finished = 1'b0;
        done_cyc = -1; fills_needed = req_mode ? 2 : 1;

        for (int c = 1; c <= 80 && !finished; c++) begin
            @(negedge clk);
            miss_req = req_mode ? ((c == 3) || (c >= 5 && r_ack2_cyc < 0)) : 1'b0;
            hready   = toggle ? (((c * 10) / 35) % 2 == 0) : 1'b1;
            hresp    = (err_beat != 0 && dph_v && beat + 1 == err_beat && hready);
            hrdata   = dph_v ? mem(dph_addr) : 32'hDEAD_BEEF;
            #1;
            if (prev_hresp) chk("err_htrans_idle", m_htrans, T_IDLE);
            if (!prev_hready && prev_htrans != T_IDLE) begin
                chk("hold_htrans", m_htrans, prev_htrans);
                chk("hold_haddr", m_haddr, prev_haddr);
            end
            if (m_miss_ack) begin
                r_ack_cnt++;
                if (r_ack2_cyc < 0) r_ack2_cyc = c;
                if (req_mode) begin
                    load_exp(addr, lw);
                    first_acc = 1'b1;
                end
            end
            if (m_crit_valid) begin
                r_crit_cnt++;
                if (r_crit_cyc < 0) begin r_crit_cyc = c; r_crit_data = m_crit_data; end
            end
            if (m_fill_valid) begin
                r_fill_cnt++;
                if (r_fill_cyc < 0) begin
                    r_fill_cyc = c; r_fill_addr = m_fill_addr; r_fill_data = m_fill_data;
                end
            end
            if (m_fill_err) begin r_err_cnt++; r_err_cyc = c; end
            if (done_cyc < 0 && (r_fill_cnt == fills_needed || r_err_cnt > 0)) done_cyc = c;

            if (hready) begin
                if (dph_v) beat++;
                dph_v = 1'b0;
                if (m_htrans == T_NONSEQ || m_htrans == T_SEQ) begin
                    chk("haddr_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("haddr", m_haddr, exp_q.pop_front());
                    chk("htrans", m_htrans, first_acc ? T_NONSEQ : T_SEQ);
                    if (first_acc) begin
                        chk("hburst", m_hburst, (lw == 8) ? 3'b100 : 3'b010);
                        if (r_nonseq_cyc < 0) r_nonseq_cyc = c;
                    end
                    first_acc = 1'b0;
                    dph_v     = 1'b1;
                    dph_addr  = m_haddr;
                end
            end
            prev_hready = hready; prev_hresp = hresp;
            prev_htrans = m_htrans; prev_haddr = m_haddr;
            if (done_cyc >= 0 && c >= done_cyc + 1) finished = 1'b1;
        end
        chk("fill_finished_in_budget", finished, 1);
        chk("end_state_idle", m_dbg, 3'd0);
        chk("end_htrans_idle", m_htrans, T_IDLE);
    endtask

    initial begin
        rstn = 1'b1; sel = 1'b0; miss_req = 1'b0; miss_addr = '0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_miss_ack", m_miss_ack, 0);
        chk("rst_htrans", m_htrans, T_IDLE);
        chk("rst_haddr", m_haddr, 0);
        chk("rst_hburst", m_hburst, 0);
        chk("rst_hsize", m_hsize, 3'b010);
        chk("rst_hwrite", m_hwrite, 0);
        chk("rst_crit_valid", m_crit_valid, 0);
        chk("rst_crit_data", m_crit_data, 0);
        chk("rst_fill_valid", m_fill_valid, 0);
        chk("rst_fill_err", m_fill_err, 0);
        chk("rst_fill_addr", m_fill_addr, 0);
        chk("rst_fill_data", m_fill_data, 0);
        chk("rst_state", m_dbg, 0);
        @(negedge clk);
        rstn = 1'b1;
        idle(2);

        // Zero-wait WRAP4 fill from 0x1008
        run_fill(32'h0000_1008, 4, 1'b0, 0, 1'b0);
        chk("a_nonseq_cyc", r_nonseq_cyc, 1);
        chk("a_crit_cyc", r_crit_cyc, 3);
        chk("a_crit_cnt", r_crit_cnt, 1);
        chk("a_crit_data", r_crit_data, mem(32'h0000_1008));
        chk("a_fill_cyc", r_fill_cyc, 6);
        chk("a_fill_cnt", r_fill_cnt, 1);
        chk("a_fill_addr", r_fill_addr, 32'h0000_1000);
        chk("a_fill_data", r_fill_data, exp_line(32'h0000_1008, 4));
        chk("a_err_cnt", r_err_cnt, 0);
        chk("a_no_extra_ack", r_ack_cnt, 0);
        idle(12);

        // hready toggling every 35 ns
        run_fill(32'h0000_1008, 4, 1'b1, 0, 1'b0);
        chk("b_crit_cnt", r_crit_cnt, 1);
        chk("b_crit_data", r_crit_data, mem(32'h0000_1008));
        chk("b_fill_cnt", r_fill_cnt, 1);
        chk("b_fill_addr", r_fill_addr, 32'h0000_1000);
        chk("b_fill_data", r_fill_data, exp_line(32'h0000_1008, 4));
        chk("b_err_cnt", r_err_cnt, 0);
        idle(12);

        // Error response on the third data beat
        run_fill(32'h0000_1008, 4, 1'b0, 3, 1'b0);
        chk("c_err_cyc", r_err_cyc, 5);
        chk("c_err_cnt", r_err_cnt, 1);
        chk("c_fill_cnt", r_fill_cnt, 0);
        chk("c_crit_cnt", r_crit_cnt, 1);
        idle(12);

        // Request pulsed during BURST, then held across DONE
        run_fill(32'h0000_1008, 4, 1'b0, 0, 1'b1);
        chk("d_ack_cnt", r_ack_cnt, 1);
        chk("d_ack2_cyc", r_ack2_cyc, 7);
        chk("d_fill_cyc", r_fill_cyc, 6);
        chk("d_fill_cnt", r_fill_cnt, 2);
        chk("d_fill_data", r_fill_data, exp_line(32'h0000_1008, 4));
        idle(12);

        // Reset in the middle of a burst
        @(negedge clk);
        miss_req = 1'b1; miss_addr = 32'h0000_1008; hready = 1'b1; hresp = 1'b0;
        #1;
        chk("e_ack", m_miss_ack, 1);
        @(negedge clk); miss_req = 1'b0; hrdata = 32'hDEAD_BEEF;
        @(negedge clk); hrdata = mem(32'h0000_1008);
        @(negedge clk); hrdata = mem(32'h0000_100C);
        #2 rstn = 1'b0;
        #1;
        chk("e_rst_htrans", m_htrans, T_IDLE);
        chk("e_rst_haddr", m_haddr, 0);
        chk("e_rst_hburst", m_hburst, 0);
        chk("e_rst_crit_valid", m_crit_valid, 0);
        chk("e_rst_crit_data", m_crit_data, 0);
        chk("e_rst_fill_addr", m_fill_addr, 0);
        chk("e_rst_fill_data", m_fill_data, 0);
        chk("e_rst_state", m_dbg, 0);
        @(negedge clk);
        rstn = 1'b1;
        cnt_fv = 0; cnt_fe = 0; cnt_cv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            hready = 1'b1; hrdata = 32'hDEAD_BEEF;
            #1;
            if (m_fill_valid) cnt_fv++;
            if (m_fill_err) cnt_fe++;
            if (m_crit_valid) cnt_cv++;
        end
        chk("e_no_fill_valid", cnt_fv, 0);
        chk("e_no_fill_err", cnt_fe, 0);
        chk("e_no_crit_valid", cnt_cv, 0);
        run_fill(32'h0000_2004, 4, 1'b0, 0, 1'b0);
        chk("e_crit_cyc", r_crit_cyc, 3);
        chk("e_crit_data", r_crit_data, mem(32'h0000_2004));
        chk("e_fill_cyc", r_fill_cyc, 6);
        chk("e_fill_addr", r_fill_addr, 32'h0000_2000);
        chk("e_fill_data", r_fill_data, exp_line(32'h0000_2004, 4));
        idle(12);

        // WRAP8 instance, critical word is the last slot of the line
        sel = 1'b1;
        run_fill(32'h0000_301C, 8, 1'b0, 0, 1'b0);
        chk("f_nonseq_cyc", r_nonseq_cyc, 1);
        chk("f_crit_cyc", r_crit_cyc, 3);
        chk("f_crit_data", r_crit_data, mem(32'h0000_301C));
        chk("f_fill_cyc", r_fill_cyc, 10);
        chk("f_fill_cnt", r_fill_cnt, 1);
        chk("f_fill_addr", r_fill_addr, 32'h0000_3000);
        chk("f_fill_data", r_fill_data, exp_line(32'h0000_301C, 8));
        chk("f_err_cnt", r_err_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_fill_controller.md
LINE_FILL_CONTROLLER -- requirements
Module: line_fill_controller

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, words per cache line; legal values 4 (WRAP4) and 8 (WRAP8) only.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port miss_req  input  1  fill request, held by requester until miss_ack.
REQ-005 SHALL have port miss_addr  input  32  missing byte address; bits [1:0] ignored.
REQ-006 SHALL have port miss_ack  output  1  one-cycle pulse: request accepted.
REQ-007 SHALL have port crit_valid / crit_data  output  1 / 32  critical (first) word forward.
REQ-008 SHALL have port fill_valid / fill_addr / fill_data  output  1 / 32 / LINE_WORDS*32  completed line, fill_addr line-aligned, word i at bits [32i+31:32i].
REQ-009 SHALL have port fill_err  output  1  one-cycle pulse: fill aborted on bus error.
REQ-010 SHALL have AHB master ports haddr(32), htrans(2), hburst(3), hsize(3), hwrite(1) outputs; hrdata(32), hready(1), hresp(1) inputs.

Function
REQ-011 SHALL drive hwrite=0 and hsize=3'b010 (word) at all times.
REQ-012 SHALL implement states IDLE, ADDR, BURST, DRAIN, DONE, ERR.
REQ-013 IDLE: htrans=IDLE, haddr=0; miss_req=1 sampled -> miss_ack pulse that cycle, latch word address, go ADDR.
REQ-014 ADDR: htrans=NONSEQ, haddr=latched word address, hburst=3'b010 (LINE_WORDS=4) or 3'b100 (LINE_WORDS=8); hready=1 -> BURST.
REQ-015 BURST: htrans=SEQ, haddr advances one wrapped word per cycle with hready=1; after LINE_WORDS addresses accepted -> DRAIN with htrans=IDLE.
REQ-016 Wrap rule: next = {addr[31:k+2], (addr[k+1:2]+1) mod LINE_WORDS, 2'b00}, k=log2(LINE_WORDS); upper bits never change within a burst.
REQ-017 hready=0 SHALL hold haddr, htrans, hburst and all beat counters unchanged.
REQ-018 Each data phase completing with hready=1, hresp=0 SHALL store hrdata into line slot addr[k+1:2] of that beat.
REQ-019 First data beat captured SHALL produce crit_valid=1 for exactly the following cycle with crit_data = that word.
REQ-020 After last beat captured SHALL enter DONE: fill_valid=1 one cycle, fill_addr = {addr[31:k+2], 0}, then IDLE.
REQ-021 Zero wait states, LINE_WORDS=4, ack in cycle T: NONSEQ T+1, SEQ T+2..T+4, crit_valid T+3, fill_valid T+6, next ack earliest T+7.
REQ-022 miss_req outside IDLE SHALL be ignored (no ack, no latch).
REQ-023 hresp=1 sampled in any data phase -> htrans=IDLE next cycle, remaining beats discarded, ERR: fill_err one cycle, no fill_valid, no crit_valid if not yet issued, then IDLE.
REQ-024 crit_valid, fill_valid, fill_err, miss_ack SHALL be zero in all other cycles; fill_data undefined when fill_valid=0 but stable during DONE.

Reset
REQ-025 rstn=0 SHALL asynchronously force state IDLE, htrans=IDLE, haddr=0, hburst=0, all pulses 0, crit_data=0, fill_addr=0, fill_data=0, counters 0.
REQ-026 Reset mid-burst SHALL abandon the line with no fill_valid or fill_err after release; first post-reset request behaves as from power-up.

Structure
REQ-027 TRANS_TYPES (IDLE, BUSY, NONSEQ, SEQ) SHALL be reused from interface_pkg; BURST_TYPES (WRAP4=3'b010, WRAP8=3'b100), HSIZE_WORD and the fill state enum SHALL be added there.
REQ-028 Wrapped-address arithmetic SHALL be one sub-module wrap_addr_gen (inputs addr, LINE_WORDS parameter; output next addr).

Verification
REQ-029 miss_addr=0x0000_1008, hready=1, LINE_WORDS=4 -> haddr 0x1008,0x100C,0x1000,0x1004; crit_data=word@0x1008; fill_valid at T+6, fill_addr=0x1000.
REQ-030 Same request, hready toggling every 35 ns on 10 ns clock -> haddr/htrans held while hready=0; same fill_data as REQ-029.
REQ-031 hresp=1 on third data beat -> htrans=IDLE next cycle, fill_err single pulse, no fill_valid, IDLE afterwards.
REQ-032 miss_req pulsed again during BURST -> no second miss_ack; after DONE, held request acked at T+7.
REQ-033 rstn=0 during BURST -> outputs at reset values immediately; new request 0x2004 after release completes normally.
REQ-034 LINE_WORDS=8, miss_addr=0x0000_301C -> hburst=3'b100, haddr 0x301C then 0x3000..0x3018; fill_addr=0x3000.
